// File: rtl/proc_run_controller_if.sv
// Processor-facing bus of the run controller: the reset and entry PC the
// controller drives, plus the PC and data-memory value the processor reports.
interface proc_run_controller_if;
   logic        proc_Reset_L;
   logic [63:0] proc_startPC;
   logic [63:0] currentPC;
   logic [63:0] dMemOut;

   modport master (
      output proc_Reset_L,
      output proc_startPC,
      input  currentPC,
      input  dMemOut
   );

   modport slave (
      input  proc_Reset_L,
      input  proc_startPC,
      output currentPC,
      output dMemOut
   );
endinterface

// File: rtl/proc_run_controller.sv
// Runs one program on an attached processor. It holds the processor in reset,
// lets it run until the end PC is reached or the watchdog expires, waits for
// memory to settle, and then compares the data-memory value with the
// expected pass code.
module proc_run_controller #(
   parameter int unsigned HOLD_CYCLES   = 1,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                   CLK,
   input  logic                   Reset,
   input  logic                   start,
   input  logic [63:0]            prog_start_pc,
   input  logic [63:0]            prog_end_pc,
   input  logic [63:0]            expected,
   input  logic [15:0]            wd_limit,
   proc_run_controller_if.master  bus,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic                   timeout,
   output logic [63:0]            result,
   output logic [15:0]            cycle_count
);

   typedef enum logic [2:0] {
      IDLE,
      RESET,
      RUN,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t      state;
   logic [63:0] end_pc_q;
   logic [63:0] expected_q;
   logic [15:0] wd_limit_q;
   logic [7:0]  hold_cnt;
   logic [7:0]  settle_cnt;
   logic [15:0] count_next;
   logic        end_hit;

   // Next RUN count (saturating) and the end-of-program test. The watchdog
   // compares against the count this RUN cycle produces, so a limit of N
   // expires at the end of the Nth RUN cycle.
   always_comb begin
      count_next = (cycle_count == 16'hFFFF) ? 16'hFFFF : cycle_count + 16'd1;
      end_hit    = (bus.currentPC >= end_pc_q);
   end

   // Status flags decode straight from the state register.
   assign busy = (state == RESET) || (state == RUN) || (state == SETTLE) || (state == CHECK);
   assign done = (state == DONE);

   // Sequencer: state, latched run parameters and all result registers.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state            <= IDLE;
         bus.proc_Reset_L <= 1'b0;
         bus.proc_startPC <= 64'd0;
         end_pc_q         <= 64'd0;
         expected_q       <= 64'd0;
         wd_limit_q       <= 16'd0;
         hold_cnt         <= 8'd0;
         settle_cnt       <= 8'd0;
         pass             <= 1'b0;
         timeout          <= 1'b0;
         result           <= 64'd0;
         cycle_count      <= 16'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               bus.proc_Reset_L <= 1'b1;
               if (start) begin
                  bus.proc_startPC <= prog_start_pc;
                  end_pc_q         <= prog_end_pc;
                  expected_q       <= expected;
                  wd_limit_q       <= (wd_limit == 16'd0) ? 16'hFFFF : wd_limit;
                  pass             <= 1'b0;
                  timeout          <= 1'b0;
                  result           <= 64'd0;
                  cycle_count      <= 16'd0;
                  hold_cnt         <= 8'd0;
                  bus.proc_Reset_L <= 1'b0;
                  state            <= RESET;
               end
            end
            RESET: begin
               if (hold_cnt == HOLD_LAST) begin
                  bus.proc_Reset_L <= 1'b1;
                  state            <= RUN;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            RUN: begin
               cycle_count <= count_next;
               if (end_hit) begin
                  settle_cnt <= 8'd0;
                  state      <= SETTLE;
               end else if (count_next == wd_limit_q) begin
                  timeout <= 1'b1;
                  pass    <= 1'b0;
                  result  <= bus.dMemOut;
                  state   <= DONE;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state <= CHECK;
               end else begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end
            CHECK: begin
               result <= bus.dMemOut;
               pass   <= (bus.dMemOut == expected_q);
               state  <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_proc_run_controller.sv
// Testbench for proc_run_controller: a small processor model steps the PC,
// a scoreboard holds the outcome predicted for each accepted start.
module tb_proc_run_controller;

   typedef struct packed {
      logic        done;
      logic        pass;
      logic        timeout;
      logic [63:0] result;
      logic [15:0] cycles;
   } exp_t;

   logic        CLK;
   logic        Reset;
   logic        start;
   logic [63:0] prog_start_pc;
   logic [63:0] prog_end_pc;
   logic [63:0] expected;
   logic [15:0] wd_limit;
   logic        busy;
   logic        done;
   logic        pass;
   logic        timeout;
   logic [63:0] result;
   logic [15:0] cycle_count;

   logic [63:0] model_pc;
   logic [63:0] dmem_val;
   logic        pc_stuck;
   logic [63:0] stuck_pc;

   int assertions;
   int failures;
   exp_t sb[$];

   proc_run_controller_if bus ();

   proc_run_controller #(
      .HOLD_CYCLES   (1),
      .SETTLE_CYCLES (1)
   ) dut (
      .CLK           (CLK),
      .Reset         (Reset),
      .start         (start),
      .prog_start_pc (prog_start_pc),
      .prog_end_pc   (prog_end_pc),
      .expected      (expected),
      .wd_limit      (wd_limit),
      .bus           (bus),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .timeout       (timeout),
      .result        (result),
      .cycle_count   (cycle_count)
   );

   // 10 ns clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Processor model: PC loads the entry point while held in reset, then
   // advances by 4 every cycle.
   always @(posedge CLK) begin
      if (bus.proc_Reset_L !== 1'b1) model_pc <= bus.proc_startPC;
      else                           model_pc <= model_pc + 64'd4;
   end

   assign bus.currentPC = pc_stuck ? stuck_pc : model_pc;
   assign bus.dMemOut   = dmem_val;

   // Predicts the run outcome by walking the processor model cycle by cycle.
   function automatic exp_t predict(input logic [63:0] spc, input logic [63:0] epc,
                                    input logic [63:0] exp_code, input logic [15:0] wd,
                                    input logic [63:0] dmem, input logic stuck,
                                    input logic [63:0] spin_pc);
      exp_t        e;
      int          lim;
      logic [63:0] pc;
      lim = (wd == 16'd0) ? 65535 : int'(wd);
      e = '0;
      e.done = 1'b1;
      for (int k = 1; k <= 70000; k++) begin
         pc = stuck ? spin_pc : spc + 64'(4 * (k - 1));
         if (pc >= epc) begin
            e.pass   = (dmem == exp_code);
            e.result = dmem;
            e.cycles = 16'(k);
            break;
         end else if (k == lim) begin
            e.timeout = 1'b1;
            e.result  = dmem;
            e.cycles  = 16'(k);
            break;
         end
      end
      return e;
   endfunction

   // Issues a one-cycle start and records the predicted outcome.
   task automatic applyStimulus(input logic [63:0] spc, input logic [63:0] epc,
                                input logic [63:0] exp_code, input logic [15:0] wd);
      @(negedge CLK);
      prog_start_pc = spc;
      prog_end_pc   = epc;
      expected      = exp_code;
      wd_limit      = wd;
      start         = 1'b1;
      sb.push_back(predict(spc, epc, exp_code, wd, dmem_val, pc_stuck, stuck_pc));
      @(negedge CLK);
      start = 1'b0;
   endtask

   // Waits (bounded) for done, counting cycles with the processor held in reset.
   task automatic wait_for_done(input int max_cycles, output int low_cycles, output bit ok);
      low_cycles = 0;
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         if (bus.proc_Reset_L === 1'b0) low_cycles++;
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(negedge CLK);
      assertions++;
      if ({bus.proc_Reset_L, busy, done, pass, timeout} !== 5'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags got %b want 00000", {bus.proc_Reset_L, busy, done, pass, timeout});
      end
      assertions++;
      if ({bus.proc_startPC, result, cycle_count} !== 144'd0) begin
         failures++;
         $display("[TB] FAIL reset_values got startPC=%h result=%h count=%h want 0",
                  bus.proc_startPC, result, cycle_count);
      end
      Reset = 1'b0;
      @(negedge CLK);
      assertions++;
      if ({bus.proc_Reset_L, busy, done} !== 3'b100) begin
         failures++;
         $display("[TB] FAIL reset_release got %b want 100", {bus.proc_Reset_L, busy, done});
      end
   endtask

   task automatic test_nominal();
      int   low;
      bit   ok;
      exp_t e;
      dmem_val = 64'hF;
      applyStimulus(64'h0, 64'h30, 64'hF, 16'd100);
      assertions++;
      if (busy !== 1'b1 || bus.proc_startPC !== 64'h0) begin
         failures++;
         $display("[TB] FAIL nominal_busy got busy=%b startPC=%h want 1 0", busy, bus.proc_startPC);
      end
      wait_for_done(200, low, ok);
      assertions++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL nominal_timeout got no done want done within 200 cycles");
      end
      assertions++;
      if (low !== 1) begin
         failures++;
         $display("[TB] FAIL nominal_hold got %0d low cycles want 1", low);
      end
      e = sb.pop_front();
      assertions++;
      if ({done, pass, timeout, result, cycle_count} !== e) begin
         failures++;
         $display("[TB] FAIL nominal_outcome got %h want %h", {done, pass, timeout, result, cycle_count}, e);
      end
   endtask

   task automatic test_done_hold();
      exp_t snap;
      bit   stable;
      snap   = {done, pass, timeout, result, cycle_count};
      stable = 1'b1;
      repeat (4) begin
         @(negedge CLK);
         if ({done, pass, timeout, result, cycle_count} !== {1'b1, 1'b1, 1'b0, 64'hF, 16'd13}) stable = 1'b0;
      end
      assertions++;
      if (!stable || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL done_hold got %h busy=%b want stable 1/1/0/F/13 busy=0",
                  {done, pass, timeout, result, cycle_count}, busy);
      end
   endtask

   task automatic test_mismatch();
      int   low;
      bit   ok;
      exp_t e;
      dmem_val = 64'hE;
      applyStimulus(64'h0, 64'h30, 64'hF, 16'd100);
      wait_for_done(200, low, ok);
      e = sb.pop_front();
      assertions++;
      if (!ok || {done, pass, timeout, result, cycle_count} !== e) begin
         failures++;
         $display("[TB] FAIL mismatch_outcome got %h want %h", {done, pass, timeout, result, cycle_count}, e);
      end
   endtask

   task automatic test_watchdog();
      int   low;
      bit   ok;
      exp_t e;
      dmem_val = 64'h5;
      pc_stuck = 1'b1;
      stuck_pc = 64'h10;
      applyStimulus(64'h0, 64'h100, 64'h5, 16'd8);
      wait_for_done(200, low, ok);
      e = sb.pop_front();
      assertions++;
      if (!ok || {done, pass, timeout, result, cycle_count} !== e) begin
         failures++;
         $display("[TB] FAIL watchdog_outcome got %h want %h", {done, pass, timeout, result, cycle_count}, e);
      end
      assertions++;
      if (cycle_count !== 16'd8 || timeout !== 1'b1) begin
         failures++;
         $display("[TB] FAIL watchdog_count got %0d/%b want 8/1", cycle_count, timeout);
      end
      pc_stuck = 1'b0;
   endtask

   task automatic test_simultaneous();
      int   low;
      bit   ok;
      exp_t e;
      dmem_val = 64'hF;
      applyStimulus(64'h0, 64'h30, 64'hF, 16'd13);
      wait_for_done(200, low, ok);
      e = sb.pop_front();
      assertions++;
      if (!ok || {done, pass, timeout, result, cycle_count} !== e) begin
         failures++;
         $display("[TB] FAIL simultaneous_outcome got %h want %h", {done, pass, timeout, result, cycle_count}, e);
      end
   endtask

   task automatic test_start_while_busy();
      int   low;
      bit   ok;
      exp_t e;
      dmem_val = 64'hF;
      applyStimulus(64'h0, 64'h30, 64'hF, 16'd100);
      repeat (3) @(negedge CLK);
      prog_start_pc = 64'h8;
      prog_end_pc   = 64'h10;
      wd_limit      = 16'd2;
      start         = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      wait_for_done(200, low, ok);
      e = sb.pop_front();
      assertions++;
      if (!ok || {done, pass, timeout, result, cycle_count} !== e) begin
         failures++;
         $display("[TB] FAIL busy_start_outcome got %h want %h", {done, pass, timeout, result, cycle_count}, e);
      end
      assertions++;
      if (bus.proc_startPC !== 64'h0) begin
         failures++;
         $display("[TB] FAIL busy_start_pc got %h want 0", bus.proc_startPC);
      end
   endtask

   task automatic test_mid_run_reset();
      bit saw_done;
      dmem_val = 64'hF;
      applyStimulus(64'h40, 64'h200, 64'hF, 16'd100);
      repeat (4) @(negedge CLK);
      sb.delete();
      Reset = 1'b1;
      @(negedge CLK);
      assertions++;
      if ({bus.proc_Reset_L, busy, done, pass, timeout, bus.proc_startPC, result, cycle_count} !== '0) begin
         failures++;
         $display("[TB] FAIL mid_reset_values got %b%b%b%b%b %h %h %h want all zero",
                  bus.proc_Reset_L, busy, done, pass, timeout, bus.proc_startPC, result, cycle_count);
      end
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         if (done !== 1'b0) saw_done = 1'b1;
      end
      Reset = 1'b0;
      @(negedge CLK);
      assertions++;
      if (saw_done || {bus.proc_Reset_L, busy, done} !== 3'b100) begin
         failures++;
         $display("[TB] FAIL mid_reset_release got done_seen=%b flags=%b want 0 100",
                  saw_done, {bus.proc_Reset_L, busy, done});
      end
   endtask

   task automatic test_back_to_back();
      int   low;
      bit   ok;
      exp_t e;
      dmem_val = 64'h1234;
      applyStimulus(64'h40, 64'h60, 64'h1234, 16'd0);
      wait_for_done(200, low, ok);
      e = sb.pop_front();
      assertions++;
      if (!ok || {done, pass, timeout, result, cycle_count} !== e) begin
         failures++;
         $display("[TB] FAIL back_to_back_first got %h want %h", {done, pass, timeout, result, cycle_count}, e);
      end
      dmem_val = 64'h99;
      applyStimulus(64'h0, 64'h8, 64'h98, 16'd50);
      assertions++;
      if (done !== 1'b0 || cycle_count !== 16'd0 || result !== 64'd0) begin
         failures++;
         $display("[TB] FAIL back_to_back_clear got done=%b count=%0d result=%h want 0 0 0",
                  done, cycle_count, result);
      end
      wait_for_done(200, low, ok);
      e = sb.pop_front();
      assertions++;
      if (!ok || {done, pass, timeout, result, cycle_count} !== e) begin
         failures++;
         $display("[TB] FAIL back_to_back_second got %h want %h", {done, pass, timeout, result, cycle_count}, e);
      end
   endtask

   // Test sequence.
   initial begin
      assertions    = 0;
      failures      = 0;
      Reset         = 1'b1;
      start         = 1'b0;
      prog_start_pc = 64'd0;
      prog_end_pc   = 64'd0;
      expected      = 64'd0;
      wd_limit      = 16'd0;
      dmem_val      = 64'd0;
      pc_stuck      = 1'b0;
      stuck_pc      = 64'd0;
      test_reset();
      test_nominal();
      test_done_hold();
      test_mismatch();
      test_watchdog();
      test_simultaneous();
      test_start_while_busy();
      test_mid_run_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
